booth_radix4_seq_mult: RTL and testbench

Sequential, parametrised radix-4 Booth multiplier, the successor to the single-digit combinational Booth encoder. It recodes the multiplier two bits per cycle and accumulates partial products into a shift/add datapath. Operands are signed or unsigned, selected per transaction. Valid/ready handshakes on input and output let it sit between pipeline stages of the ALU/MAC datapath.

---
 rtl/booth_radix4_seq_mult.sv | 127 ++++++++++++
 tb/tb_booth_radix4_seq_mult.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per transaction.
// Valid/ready handshakes on operands and product, one Booth digit per cycle.
module booth_radix4_seq_mult #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int AW   = 2 * WIDTH + 4;
  localparam int BW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_radix4_seq_mult: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [AW-1:0]      r_a;
  logic [AW-1:0]      r_acc;
  logic [AW-1:0]      w_pp;
  logic [AW-1:0]      w_acc_nxt;
  logic [BW-1:0]      r_b;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_product;
  logic               w_accept;
  logic               w_last;
  logic               w_sa;
  logic               w_sb;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_CALC);
  assign out_valid = (r_state == S_DONE);
  assign product   = r_product;

  assign w_sa = signed_mode & a[WIDTH-1];
  assign w_sb = signed_mode & b[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        if (r_cnt == CW'(ITER - 1)) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_a is pre-shifted by 4^i, so the digit only picks 0, +-A or +-2A
  always_comb begin
    w_pp = '0;
    unique case (r_b[2:0])
      3'b001, 3'b010: w_pp = r_a;
      3'b101, 3'b110: w_pp = -r_a;
      3'b011:         w_pp = {r_a[AW-2:0], 1'b0};
      3'b100:         w_pp = -{r_a[AW-2:0], 1'b0};
      default:        w_pp = '0;
    endcase
  end

  assign w_acc_nxt = r_acc + w_pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_a   <= {{(WIDTH + 4){w_sa}}, a};
      r_b   <= {{2{w_sb}}, b, 1'b0};
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      r_a   <= {r_a[AW-3:0], 2'b00};
      r_b   <= {2'b00, r_b[BW-1:2]};
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        r_product <= w_acc_nxt[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq_mult.sv
// Bench for booth_radix4_seq_mult: directed cases at WIDTH=32 and a
// randomised sweep at WIDTH=8 and 32 against plain-arithmetic products.
module tb_booth_radix4_seq_mult;

  localparam int W   = 32;
  localparam int IT  = W / 2 + 1;
  localparam int W8  = 8;
  localparam int IT8 = W8 / 2 + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_ready, sm;
  logic          out_valid, out_ready, busy;
  logic [W-1:0]  a, b;
  logic [63:0]   product;

  logic          rst8, in_valid8, in_ready8, sm8;
  logic          out_valid8, out_ready8, busy8;
  logic [7:0]    a8, b8;
  logic [15:0]   product8;

  booth_radix4_seq_mult #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(sm),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  booth_radix4_seq_mult #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst8),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .signed_mode(sm8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .product(product8), .busy(busy8)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref32(input logic [31:0] x,
                                        input logic [31:0] y,
                                        input logic s);
    if (s) return longint'($signed(x)) * longint'($signed(y));
    return {32'b0, x} * {32'b0, y};
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] x,
                                       input logic [7:0] y,
                                       input logic s);
    int p;
    if (s) p = int'($signed(x)) * int'($signed(y));
    else p = int'({24'b0, x}) * int'({24'b0, y});
    return p[15:0];
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    logic [31:0] r;
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'hFF;
      3: return 8'h80;
      4: return 8'h7F;
      default: begin
        r = $urandom;
        return r[7:0];
      end
    endcase
  endfunction

  // Scoreboards: model products pushed on input handshake, popped on output
  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [63:0] oprod[$];
  int          ocyc[$];
  int          acc_e32, acc_e8;
  bit          lat_p32, lat_p8, hold32, hold8;
  logic [63:0] prev32, e32;
  logic [15:0] prev8, e8;

  always @(negedge clk) begin
    if (rst) begin
      q32.delete();
      lat_p32 = 1'b0;
      hold32  = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        q32.push_back(ref32(a, b, sm));
        acc_e32 = cyc + 1;
        lat_p32 = 1'b1;
      end
      if (out_valid && lat_p32) begin
        lat_p32 = 1'b0;
        chk("latency32", 64'(cyc - acc_e32), 64'(IT));
      end
      if (out_valid) begin
        chk("flags32", {in_ready, busy}, 2'b00);
      end
      if (out_valid && hold32) begin
        chk("stable32", product, prev32);
      end
      if (out_valid && out_ready) begin
        if (q32.size() == 0) begin
          chk("spurious32", 1, 0);
        end else begin
          e32 = q32.pop_front();
          chk("prod32", product, e32);
        end
        oprod.push_back(product);
        ocyc.push_back(cyc + 1);
      end
      hold32 = out_valid && !out_ready;
      prev32 = product;
    end
  end

  always @(negedge clk) begin
    if (rst8) begin
      q8.delete();
      lat_p8 = 1'b0;
      hold8  = 1'b0;
    end else begin
      if (in_valid8 && in_ready8) begin
        q8.push_back(ref8(a8, b8, sm8));
        acc_e8 = cyc + 1;
        lat_p8 = 1'b1;
      end
      if (out_valid8 && lat_p8) begin
        lat_p8 = 1'b0;
        chk("latency8", 64'(cyc - acc_e8), 64'(IT8));
      end
      if (out_valid8 && hold8) begin
        chk("stable8", 64'(product8), 64'(prev8));
      end
      if (out_valid8 && out_ready8) begin
        if (q8.size() == 0) begin
          chk("spurious8", 1, 0);
        end else begin
          e8 = q8.pop_front();
          chk("prod8", 64'(product8), 64'(e8));
        end
      end
      hold8 = out_valid8 && !out_ready8;
      prev8 = product8;
    end
  end

  task automatic wait_in_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout32", 0, 1);
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout32", 0, 1);
  endtask

  task automatic drive_in(input logic [31:0] x, input logic [31:0] y,
                          input logic s);
    a = x; b = y; sm = s; in_valid = 1'b1;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic op32(input logic [31:0] x, input logic [31:0] y,
                      input logic s, output logic [63:0] res);
    drive_in(x, y, s);
    out_ready = 1'b1;
    wait_out_valid();
    res = product;
    @(posedge clk); #1;
  endtask

  task automatic check_idle32(input string nm);
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    chk({nm, "_out_valid"}, out_valid, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_product"}, product, 64'h0);
  endtask

  task automatic t32();
    logic [63:0] r, hold;
    int n0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle32("reset32");

    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, r);
    chk("m1xm1_signed", r, 64'h0000_0000_0000_0001);
    op32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r);
    chk("max_unsigned", r, 64'hFFFF_FFFE_0000_0001);
    op32(32'h8000_0000, 32'h8000_0000, 1'b1, r);
    chk("min_x_min", r, 64'h4000_0000_0000_0000);

    // backpressure with new operands waving around
    drive_in(32'd1234567, 32'hFFFF_0003, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    wait_out_valid();
    hold = product;
    chk("bp_value", hold, ref32(32'd1234567, 32'hFFFF_0003, 1'b1));
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; sm = ~sm;
      @(posedge clk); #1;
      chk("bp_hold", product, hold);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_release_in_ready", in_ready, 1'b1);

    // reset in the middle of CALC
    drive_in(32'd99, 32'd77, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_idle32("midreset");
    op32(32'd7, 32'hFFFF_FFFD, 1'b1, r);
    chk("7xm3", r, 64'hFFFF_FFFF_FFFF_FFEB);

    // back-to-back with both sides always willing
    n0 = oprod.size();
    out_ready = 1'b1;
    sm = 1'b0;
    in_valid = 1'b1;
    a = 32'd3; b = 32'd5;
    wait_in_ready();
    @(posedge clk); #1;
    a = 32'd0; b = 32'h1234_5678;
    wait_in_ready();
    @(posedge clk); #1;
    a = 32'h7FFF_FFFF; b = 32'd2;
    wait_in_ready();
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out_valid();
    repeat (2) @(posedge clk);
    #1;
    if (oprod.size() < n0 + 3) begin
      chk("b2b_count", 64'(oprod.size() - n0), 64'd3);
    end else begin
      chk("b2b_0", oprod[n0], 64'd15);
      chk("b2b_1", oprod[n0+1], 64'd0);
      chk("b2b_2", oprod[n0+2], 64'hFFFF_FFFE);
      chk("b2b_gap01", 64'(ocyc[n0+1] - ocyc[n0]), 64'(IT + 2));
      chk("b2b_gap12", 64'(ocyc[n0+2] - ocyc[n0+1]), 64'(IT + 2));
    end

    // random sweep with random output stalls
    for (int k = 0; k < 80; k++) begin
      drive_in(pick32(), pick32(), 1'($urandom_range(0, 1)));
      out_ready = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      wait_out_valid();
      repeat ($urandom_range(0, 3)) begin
        a = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1 chk("drain32", 64'(q32.size()), 64'd0);
  endtask

  task automatic t8();
    int n;
    rst8 = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0;
    chk("reset8", {in_ready8, out_valid8, busy8, product8}, {3'b100, 16'h0});
    for (int k = 0; k < 200; k++) begin
      a8 = pick8(); b8 = pick8(); sm8 = 1'($urandom_range(0, 1));
      in_valid8 = 1'b1;
      n = 0;
      while (!in_ready8 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready8) chk("in_ready_timeout8", 0, 1);
      @(posedge clk); #1;
      in_valid8 = 1'($urandom_range(0, 1));
      out_ready8 = 1'($urandom_range(0, 1));
      n = 0;
      while (!(out_valid8 && out_ready8) && n < 100) begin
        @(posedge clk); #1;
        out_ready8 = 1'($urandom_range(0, 1));
        a8 = pick8();
        n++;
      end
      if (n >= 100) chk("out_timeout8", 0, 1);
      in_valid8 = 1'b0;
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1 chk("drain8", 64'(q8.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sm = 1'b0;
    rst8 = 1'b1; in_valid8 = 1'b0; out_ready8 = 1'b0;
    a8 = '0; b8 = '0; sm8 = 1'b0;
    fork
      t32();
      t8();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
